// File: rtl/ulpi_link_ctrl.sv
// ulpi_link_ctrl: ULPI link-layer controller in the 60 MHz ULPI clock domain.
//   - PHY register read/write from a single-request port (reg_*)
//   - one-packet USB transmit from a valid/ready byte stream (tx_*)
//   - RX CMD capture with sticky change interrupt, and received USB bytes (rx_*)
// Ports:
//   aclk, areset        ULPI clock, synchronous active-high reset
//   ULPI_data_i/_o/_t   bidirectional bus split; _t = 1 releases the bus
//   ULPI_stp/dir/nxt    ULPI control lines
//   reg_req/we/addr/wdata -> reg_ack/err/rdata      register access
//   tx_valid/data/last  -> tx_ready/done/err        packet transmit
//   rx_valid/data/last, rx_cmd/rx_cmd_valid         receive side
//   irq_clr -> interrupt                            RX CMD change interrupt
module ulpi_link_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_W           = 7,
  parameter logic [7:0]  RXCMD_IRQ_MASK = 8'h03
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic [7:0] ULPI_data_i,
  output logic [7:0] ULPI_data_o,
  output logic [7:0] ULPI_data_t,
  output logic       ULPI_stp,
  input  logic       ULPI_dir,
  input  logic       ULPI_nxt,
  input  logic       reg_req,
  input  logic       reg_we,
  input  logic [5:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic       reg_ack,
  output logic       reg_err,
  output logic [7:0] reg_rdata,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_last,
  output logic [7:0] rx_cmd,
  output logic       rx_cmd_valid,
  input  logic       irq_clr,
  output logic       interrupt
);

  typedef enum logic [3:0] {
    IDLE, RW_CMD, RW_DATA, RW_STP, RD_CMD, RD_TURN, RD_DATA, TX_CMD, TX_DATA, TX_STP
  } state_t;

  state_t          state_q, state_d;
  logic            dir_q;
  logic [TO_W-1:0] to_q, to_d;
  logic [5:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            abt_q, abt_d;
  logic            reg_ack_q, reg_ack_d, reg_err_q, reg_err_d;
  logic            tx_done_q, tx_done_d, tx_err_q, tx_err_d;

  logic [7:0]      rx_cmd_q;
  logic            rx_cmd_valid_q;
  logic            irq_q;
  logic [7:0]      buf_q;
  logic            buf_full_q;
  logic            rx_valid_q, rx_last_q;
  logic [7:0]      rx_data_q;

  logic rx_own, rxcmd_ev, rxdat_ev, dir_fall, timeout, irq_set;

  // PHY owns the bus only once both dir and its registered copy are high.
  assign rx_own   = ULPI_dir & dir_q;
  // During a register read the non-nxt byte is register data, not an RX CMD.
  assign rxcmd_ev = rx_own & ~ULPI_nxt & (state_q != RD_DATA);
  assign rxdat_ev = rx_own & ULPI_nxt;
  assign dir_fall = ~ULPI_dir & dir_q;
  assign timeout  = (to_q == TO_W'(TIMEOUT_CYCLES - 1)) & ~ULPI_nxt;
  assign irq_set  = rxcmd_ev & (((ULPI_data_i ^ rx_cmd_q) & RXCMD_IRQ_MASK) != 8'h00);

  assign ULPI_data_t = {8{areset | ULPI_dir | dir_q}};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    abt_d     = abt_q;
    reg_ack_d = 1'b0;
    reg_err_d = 1'b0;
    tx_done_d = 1'b0;
    tx_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        abt_d = 1'b0;
        if (!ULPI_dir && !dir_q) begin
          if (reg_req) begin
            addr_d  = reg_addr;
            wdata_d = reg_wdata;
            state_d = reg_we ? RW_CMD : RD_CMD;
          end else if (tx_valid) begin
            state_d = TX_CMD;
          end
        end
      end
      RW_CMD, RD_CMD, RW_DATA: begin
        if (ULPI_dir) begin
          state_d   = IDLE;
          reg_ack_d = 1'b1;
          reg_err_d = 1'b1;
        end else if (ULPI_nxt) begin
          if (state_q == RW_CMD)       state_d = RW_DATA;
          else if (state_q == RD_CMD)  state_d = RD_TURN;
          else begin
            state_d   = RW_STP;
            reg_ack_d = 1'b1;
          end
        end else if (timeout) begin
          state_d   = RW_STP;
          reg_ack_d = 1'b1;
          reg_err_d = 1'b1;
        end
      end
      RW_STP: state_d = IDLE;
      RD_TURN: begin
        if (ULPI_dir) begin
          state_d = RD_DATA;
        end else if (timeout) begin
          state_d   = RW_STP;
          reg_ack_d = 1'b1;
          reg_err_d = 1'b1;
        end
      end
      RD_DATA: begin
        state_d   = IDLE;
        reg_ack_d = 1'b1;
        if (rx_own && !ULPI_nxt) rdata_d   = ULPI_data_i;
        else                     reg_err_d = 1'b1;   // preempted by RX or PHY dropped dir
      end
      TX_CMD, TX_DATA: begin
        if (ULPI_dir) begin
          state_d   = IDLE;
          tx_done_d = 1'b1;
          tx_err_d  = 1'b1;
        end else if (ULPI_nxt && (state_q == TX_CMD || tx_valid)) begin
          if (tx_last) begin
            state_d   = TX_STP;
            tx_done_d = 1'b1;
          end else begin
            state_d = TX_DATA;
          end
        end else if (ULPI_nxt || timeout) begin
          // underrun or no throttle release: stp with FF aborts the packet
          state_d   = TX_STP;
          abt_d     = 1'b1;
          tx_done_d = 1'b1;
          tx_err_d  = 1'b1;
        end
      end
      TX_STP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    to_d = ((state_d != state_q) || ULPI_nxt) ? '0 : to_q + 1'b1;
  end

  always_comb begin
    ULPI_data_o = '0;
    ULPI_stp    = 1'b0;
    tx_ready    = 1'b0;
    if (!areset) begin
      case (state_q)
        RW_CMD:  ULPI_data_o = {2'b10, addr_q};
        RW_DATA: ULPI_data_o = wdata_q;
        RW_STP:  ULPI_stp    = 1'b1;
        RD_CMD:  ULPI_data_o = {2'b11, addr_q};
        TX_CMD: begin
          ULPI_data_o = {4'b0100, tx_data[3:0]};
          tx_ready    = ULPI_nxt & ~ULPI_dir;
        end
        TX_DATA: begin
          ULPI_data_o = tx_valid ? tx_data : '0;
          tx_ready    = ULPI_nxt & tx_valid & ~ULPI_dir;
        end
        TX_STP: begin
          ULPI_stp    = 1'b1;
          ULPI_data_o = abt_q ? '1 : '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q        <= IDLE;
      dir_q          <= 1'b0;
      to_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      abt_q          <= 1'b0;
      reg_ack_q      <= 1'b0;
      reg_err_q      <= 1'b0;
      tx_done_q      <= 1'b0;
      tx_err_q       <= 1'b0;
      rx_cmd_q       <= '0;
      rx_cmd_valid_q <= 1'b0;
      irq_q          <= 1'b0;
      buf_q          <= '0;
      buf_full_q     <= 1'b0;
      rx_valid_q     <= 1'b0;
      rx_last_q      <= 1'b0;
      rx_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      dir_q          <= ULPI_dir;
      to_q           <= to_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rdata_q        <= rdata_d;
      abt_q          <= abt_d;
      reg_ack_q      <= reg_ack_d;
      reg_err_q      <= reg_err_d;
      tx_done_q      <= tx_done_d;
      tx_err_q       <= tx_err_d;
      rx_cmd_valid_q <= rxcmd_ev;
      if (rxcmd_ev) rx_cmd_q <= ULPI_data_i;
      if (irq_set)      irq_q <= 1'b1;
      else if (irq_clr) irq_q <= 1'b0;
      // One-byte hold lets the final byte be tagged rx_last when dir falls.
      rx_valid_q <= 1'b0;
      rx_last_q  <= 1'b0;
      if (rxdat_ev) begin
        if (buf_full_q) begin
          rx_valid_q <= 1'b1;
          rx_data_q  <= buf_q;
        end
        buf_q      <= ULPI_data_i;
        buf_full_q <= 1'b1;
      end else if (dir_fall && buf_full_q) begin
        rx_valid_q <= 1'b1;
        rx_last_q  <= 1'b1;
        rx_data_q  <= buf_q;
        buf_full_q <= 1'b0;
      end
    end
  end

  assign reg_ack      = reg_ack_q;
  assign reg_err      = reg_err_q;
  assign reg_rdata    = rdata_q;
  assign tx_done      = tx_done_q;
  assign tx_err       = tx_err_q;
  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign rx_last      = rx_last_q;
  assign rx_cmd       = rx_cmd_q;
  assign rx_cmd_valid = rx_cmd_valid_q;
  assign interrupt    = irq_q;

endmodule

// File: tb/tb_ulpi_link_ctrl.sv
// Scoreboard bench for ulpi_link_ctrl: expected bus bytes, stp bytes, register
// completions, tx completions, RX bytes and RX CMDs are queued as stimulus is
// driven and compared by a negedge monitor as the DUT produces them.
module tb_ulpi_link_ctrl;

  logic       aclk = 1'b0;
  logic       areset;
  logic [7:0] ULPI_data_i, ULPI_data_o, ULPI_data_t;
  logic       ULPI_stp, ULPI_dir, ULPI_nxt;
  logic       reg_req, reg_we;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  logic       reg_ack, reg_err;
  logic       tx_valid, tx_last, tx_ready, tx_done, tx_err;
  logic [7:0] tx_data;
  logic       rx_valid, rx_last, rx_cmd_valid;
  logic [7:0] rx_data, rx_cmd;
  logic       irq_clr, interrupt;

  ulpi_link_ctrl #(
    .TIMEOUT_CYCLES(64),
    .TO_W(7),
    .RXCMD_IRQ_MASK(8'h03)
  ) dut (
    .aclk(aclk), .areset(areset),
    .ULPI_data_i(ULPI_data_i), .ULPI_data_o(ULPI_data_o), .ULPI_data_t(ULPI_data_t),
    .ULPI_stp(ULPI_stp), .ULPI_dir(ULPI_dir), .ULPI_nxt(ULPI_nxt),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last),
    .rx_cmd(rx_cmd), .rx_cmd_valid(rx_cmd_valid),
    .irq_clr(irq_clr), .interrupt(interrupt)
  );

  always #5 aclk = ~aclk;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  logic [7:0] q_bus[$];
  logic [7:0] q_stp[$];
  logic [9:0] q_ack[$];   // {err, compare_rdata, rdata}
  logic       q_done[$];  // expected tx_err
  logic [8:0] q_rx[$];    // {last, data}
  logic [7:0] q_cmd[$];

  logic [7:0] pkt [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  always @(negedge aclk) begin
    if (!areset) begin
      if (ULPI_nxt && ULPI_data_t == 8'h00 && !ULPI_stp) begin
        check("bus_expected", q_bus.size() != 0, 1);
        if (q_bus.size() != 0) check("bus_byte", ULPI_data_o, q_bus.pop_front());
      end
      if (ULPI_stp) begin
        check("stp_expected", q_stp.size() != 0, 1);
        if (q_stp.size() != 0) check("stp_byte", ULPI_data_o, q_stp.pop_front());
      end
      if (reg_ack) begin
        check("ack_expected", q_ack.size() != 0, 1);
        if (q_ack.size() != 0) begin
          logic [9:0] e;
          e = q_ack.pop_front();
          check("reg_err", reg_err, e[9]);
          if (e[8]) check("reg_rdata", reg_rdata, e[7:0]);
        end
      end else if (reg_err) begin
        check("reg_err_alone", reg_err, 0);
      end
      if (tx_done) begin
        check("done_expected", q_done.size() != 0, 1);
        if (q_done.size() != 0) check("tx_err", tx_err, q_done.pop_front());
      end else if (tx_err) begin
        check("tx_err_alone", tx_err, 0);
      end
      if (rx_valid) begin
        check("rx_expected", q_rx.size() != 0, 1);
        if (q_rx.size() != 0) check("rx_byte", {rx_last, rx_data}, q_rx.pop_front());
      end
      if (rx_cmd_valid) begin
        check("rxcmd_expected", q_cmd.size() != 0, 1);
        if (q_cmd.size() != 0) check("rx_cmd", rx_cmd, q_cmd.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned idx, rdy, wait_n;
    logic seen;
    pkt[0] = 8'hC3; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33;
    areset = 1'b1; ULPI_data_i = '0; ULPI_dir = 1'b0; ULPI_nxt = 1'b0;
    reg_req = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
    tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0; irq_clr = 1'b0;
    repeat (3) @(posedge aclk);
    #2;
    check("rst_data_o", ULPI_data_o, 8'h00);
    check("rst_data_t", ULPI_data_t, 8'hFF);
    check("rst_stp", ULPI_stp, 0);
    check("rst_reg_ack", reg_ack, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_cmd", rx_cmd, 8'h00);
    check("rst_irq", interrupt, 0);
    check("rst_rdata", reg_rdata, 8'h00);
    tick(); areset = 1'b0;
    tick(); #1 check("idle_data_t", ULPI_data_t, 8'h00);

    // register write 0x0A <= 0x45
    tick(); reg_req = 1; reg_we = 1; reg_addr = 6'h0A; reg_wdata = 8'h45;
    q_bus.push_back(8'h8A); q_bus.push_back(8'h45); q_stp.push_back(8'h00);
    q_ack.push_back({1'b0, 1'b0, 8'h00});
    tick(); reg_req = 0;
    tick(); ULPI_nxt = 1;
    tick(); ULPI_nxt = 1;
    tick(); ULPI_nxt = 0; #1 check("wr_stp", ULPI_stp, 1);
    tick(); #1 check("wr_stp_one_cycle", ULPI_stp, 0);

    // register read 0x16 -> 0x5C
    tick(); reg_req = 1; reg_we = 0; reg_addr = 6'h16;
    q_bus.push_back(8'hD6); q_ack.push_back({1'b0, 1'b1, 8'h5C});
    tick(); reg_req = 0; ULPI_nxt = 1;
    tick(); ULPI_nxt = 0; ULPI_dir = 1; #1 check("rd_turn_release", ULPI_data_t, 8'hFF);
    tick(); ULPI_data_i = 8'h5C; #1 check("rd_data_release", ULPI_data_t, 8'hFF);
    tick(); ULPI_dir = 0; ULPI_data_i = 8'h00;
    #1 check("rd_fall_release", ULPI_data_t, 8'hFF); check("rd_ack", reg_ack, 1);
    tick(); #1 check("rd_bus_back", ULPI_data_t, 8'h00); check("rd_ack_pulse", reg_ack, 0);
    tick(); #1 check("rd_rdata_held", reg_rdata, 8'h5C);

    // transmit PID C3 + 11 22 33, nxt every other cycle
    tick(); tx_valid = 1; tx_data = 8'hC3; tx_last = 0;
    q_bus.push_back(8'h43); q_bus.push_back(8'h11); q_bus.push_back(8'h22); q_bus.push_back(8'h33);
    q_stp.push_back(8'h00); q_done.push_back(1'b0);
    idx = 0; rdy = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (idx < 4) begin
        tx_valid = 1; tx_data = pkt[idx]; tx_last = (idx == 3); ULPI_nxt = (k % 2 == 1);
      end else begin
        tx_valid = 0; tx_last = 0; ULPI_nxt = 0;
      end
      #1;
      if (tx_ready) begin idx++; rdy++; end
      if (tx_done) seen = 1;
    end
    check("tx_ready_count", rdy, 4);
    check("tx_done_seen", seen, 1);
    tick();

    // RX CMDs 01, 02 then packet A0 A1 A2
    tick(); ULPI_dir = 1; ULPI_data_i = 8'hEE;
    tick(); ULPI_data_i = 8'h01; q_cmd.push_back(8'h01);
    tick(); ULPI_data_i = 8'h02; q_cmd.push_back(8'h02);
    tick(); ULPI_nxt = 1; ULPI_data_i = 8'hA0; q_rx.push_back({1'b0, 8'hA0});
    tick(); ULPI_data_i = 8'hA1; q_rx.push_back({1'b0, 8'hA1});
    tick(); ULPI_data_i = 8'hA2; q_rx.push_back({1'b1, 8'hA2});
    tick(); ULPI_dir = 0; ULPI_nxt = 0; ULPI_data_i = 8'h00;
    tick(); tick(); #1 check("irq_set", interrupt, 1);
    tick(); irq_clr = 1;
    tick(); irq_clr = 0; #1 check("irq_cleared", interrupt, 0);

    // set wins over clear; clear applies when the RX CMD does not change masked bits
    tick(); ULPI_dir = 1; ULPI_data_i = 8'hEE;
    tick(); ULPI_data_i = 8'h03; irq_clr = 1; q_cmd.push_back(8'h03);
    tick(); q_cmd.push_back(8'h03); #1 check("irq_set_wins", interrupt, 1);
    tick(); ULPI_dir = 0; irq_clr = 0; ULPI_data_i = 8'h00; #1 check("irq_clear_nochange", interrupt, 0);
    tick();

    // write timeout: nxt never asserted
    tick(); reg_req = 1; reg_we = 1; reg_addr = 6'h05; reg_wdata = 8'h77;
    q_ack.push_back({1'b1, 1'b0, 8'h00}); q_stp.push_back(8'h00);
    tick(); reg_req = 0; #1;
    wait_n = 1;
    while (!reg_ack && wait_n < 100) begin tick(); #1; wait_n++; end
    check("timeout_cycles", wait_n, 65);
    check("timeout_stp", ULPI_stp, 1);
    tick(); #1 check("timeout_stp_one_cycle", ULPI_stp, 0);

    // dir rises during TX_DATA
    tick(); tx_valid = 1; tx_data = 8'hD2; tx_last = 0;
    q_bus.push_back(8'h42); q_done.push_back(1'b1);
    tick(); ULPI_nxt = 1; #1 check("abt_cmd_ready", tx_ready, 1);
    tick(); ULPI_nxt = 0; tx_data = 8'h55; ULPI_dir = 1;
    #1 check("abt_release", ULPI_data_t, 8'hFF); check("abt_no_ready", tx_ready, 0);
    tick(); ULPI_dir = 0; tx_valid = 0; #1 check("abt_done", tx_done, 1); check("abt_err", tx_err, 1);
    tick(); #1 check("abt_bus_back", ULPI_data_t, 8'h00); check("abt_no_stp", ULPI_stp, 0);

    // read preempted by RX data: ack+err, bytes go to RX path
    tick(); reg_req = 1; reg_we = 0; reg_addr = 6'h01;
    q_bus.push_back(8'hC1); q_ack.push_back({1'b1, 1'b0, 8'h00});
    q_rx.push_back({1'b0, 8'hB7}); q_rx.push_back({1'b1, 8'hB8});
    tick(); reg_req = 0; ULPI_nxt = 1;
    tick(); ULPI_nxt = 0; ULPI_dir = 1;
    tick(); ULPI_nxt = 1; ULPI_data_i = 8'hB7;
    tick(); ULPI_data_i = 8'hB8; #1 check("pre_ack", reg_ack, 1); check("pre_err", reg_err, 1);
    tick(); ULPI_dir = 0; ULPI_nxt = 0; ULPI_data_i = 8'h00;
    tick(); tick();

    // reset asserted during RD_DATA
    tick(); reg_req = 1; reg_we = 0; reg_addr = 6'h16; q_bus.push_back(8'hD6);
    tick(); reg_req = 0; ULPI_nxt = 1;
    tick(); ULPI_nxt = 0; ULPI_dir = 1;
    tick(); ULPI_data_i = 8'h99; areset = 1;
    tick(); areset = 0; ULPI_dir = 0; ULPI_data_i = 8'h00;
    #1;
    check("mr_reg_ack", reg_ack, 0);
    check("mr_rdata", reg_rdata, 8'h00);
    check("mr_rx_cmd", rx_cmd, 8'h00);
    check("mr_irq", interrupt, 0);
    check("mr_data_o", ULPI_data_o, 8'h00);
    check("mr_stp", ULPI_stp, 0);
    check("mr_data_t", ULPI_data_t, 8'h00);
    tick(); #1 check("mr_no_late_ack", reg_ack, 0);
    tick(); tick();

    check("q_bus_drained", q_bus.size(), 0);
    check("q_stp_drained", q_stp.size(), 0);
    check("q_ack_drained", q_ack.size(), 0);
    check("q_done_drained", q_done.size(), 0);
    check("q_rx_drained", q_rx.size(), 0);
    check("q_cmd_drained", q_cmd.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
